// File: rtl/shift_collector_16bit.sv
// Serial-to-parallel collector for an LSB-first bit stream produced by a right shift register.
// Rebuilds the WIDTH-bit word, raises word_valid until acked, and flags bits that arrive while a word is pending.
module shift_collector_16bit #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             word_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             word_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ovr_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      data_out <= '0;
      bit_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_out <= data_nxt;
      bit_cnt  <= cnt_nxt;
      overrun  <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    cnt_nxt   = bit_cnt;
    ovr_nxt   = overrun;
    // start overrides any in-flight bit or ack in the same cycle
    if (start) begin
      state_nxt = COLLECT;
      data_nxt  = '0;
      cnt_nxt   = '0;
      ovr_nxt   = 1'b0;
    end else begin
      case (state)
        COLLECT: if (ser_valid) begin
          data_nxt = {ser_in, data_out[WIDTH-1:1]};
          cnt_nxt  = bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) state_nxt = FULL;
        end
        FULL: begin
          if (ser_valid) ovr_nxt = 1'b1;
          if (word_ack)  state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == COLLECT);
  assign word_valid = (state == FULL);

endmodule

// File: tb/tb_shift_collector_16bit.sv
// Directed bench for shift_collector_16bit; each check compares a packed status word
// {data_out, bit_cnt (8b), 1'b0, word_valid, busy, overrun} against a hand-computed value.
module tb_shift_collector_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, ser_in = 1'b0, ser_valid = 1'b0, word_ack = 1'b0;
  logic [15:0] data_out;
  logic        word_valid, busy, overrun;
  logic [4:0]  bit_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  shift_collector_16bit dut (
    .clk(clk), .rst(rst), .start(start), .ser_in(ser_in), .ser_valid(ser_valid),
    .word_ack(word_ack), .data_out(data_out), .word_valid(word_valid), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  wire [27:0] st = {data_out, 3'b000, bit_cnt, 1'b0, word_valid, busy, overrun};

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_in = b; ser_valid = 1'b1; tick(); ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic do_ack();
    word_ack = 1'b1; tick(); word_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    vectors++;
    if (st !== 28'h0000_00_0) begin
      $display("FAIL reset_state: got %h want %h", st, 28'h0000_00_0); miscompares++;
    end
  endtask

  task automatic test_basic();
    logic [15:0] w;
    w = 16'hA5C3;
    do_start();
    vectors++;
    if (st !== 28'h0000_00_2) begin
      $display("FAIL basic_start: got %h want %h", st, 28'h0000_00_2); miscompares++;
    end
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    vectors++;
    if (st !== 28'hC300_08_2) begin
      $display("FAIL basic_8bits: got %h want %h", st, 28'hC300_08_2); miscompares++;
    end
    for (int i = 8; i < 15; i++) send_bit(w[i]);
    vectors++;
    if (st !== 28'h4B86_0F_2) begin
      $display("FAIL basic_15bits: got %h want %h", st, 28'h4B86_0F_2); miscompares++;
    end
    send_bit(w[15]);
    vectors++;
    if (st !== 28'hA5C3_10_4) begin
      $display("FAIL basic_full: got %h want %h", st, 28'hA5C3_10_4); miscompares++;
    end
    do_ack();
    vectors++;
    if (st !== 28'hA5C3_10_0) begin
      $display("FAIL basic_ack: got %h want %h", st, 28'hA5C3_10_0); miscompares++;
    end
  endtask

  task automatic test_gapped();
    logic [15:0] w;
    int cyc;
    w = 16'h8001;
    cyc = 0;
    do_start();
    for (int i = 0; i < 16; i++) begin
      tick(); cyc++;
      if (i == 5) begin
        vectors++;
        if (st !== 28'h0800_05_2) begin
          $display("FAIL gapped_hold: got %h want %h", st, 28'h0800_05_2); miscompares++;
        end
      end
      if (i == 15) begin
        vectors++;
        if (word_valid !== 1'b0) begin
          $display("FAIL gapped_early_valid: got %b want 0 at cycle %0d", word_valid, cyc); miscompares++;
        end
      end
      send_bit(w[i]); cyc++;
    end
    vectors++;
    if (st !== 28'h8001_10_4 || cyc !== 32) begin
      $display("FAIL gapped_full: got %h after %0d cycles want %h after 32", st, cyc, 28'h8001_10_4);
      miscompares++;
    end
    do_ack();
  endtask

  task automatic test_restart();
    do_start();
    for (int i = 0; i < 9; i++) send_bit(1'b1);
    start = 1'b1; ser_in = 1'b1; ser_valid = 1'b1; tick();
    start = 1'b0; ser_valid = 1'b0;
    vectors++;
    if (st !== 28'h0000_00_2) begin
      $display("FAIL restart_clear: got %h want %h", st, 28'h0000_00_2); miscompares++;
    end
    send_word(16'h1234);
    vectors++;
    if (st !== 28'h1234_10_4) begin
      $display("FAIL restart_word: got %h want %h", st, 28'h1234_10_4); miscompares++;
    end
    do_ack();
  endtask

  task automatic test_overrun();
    do_start();
    send_word(16'hFFFF);
    vectors++;
    if (st !== 28'hFFFF_10_4) begin
      $display("FAIL ovr_full: got %h want %h", st, 28'hFFFF_10_4); miscompares++;
    end
    send_bit(1'b0);
    tick();
    send_bit(1'b0);
    vectors++;
    if (st !== 28'hFFFF_10_5) begin
      $display("FAIL ovr_set: got %h want %h", st, 28'hFFFF_10_5); miscompares++;
    end
    do_ack();
    vectors++;
    if (st !== 28'hFFFF_10_1) begin
      $display("FAIL ovr_after_ack: got %h want %h", st, 28'hFFFF_10_1); miscompares++;
    end
    do_start();
    vectors++;
    if (st !== 28'h0000_00_2) begin
      $display("FAIL ovr_clear: got %h want %h", st, 28'h0000_00_2); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    rst = 1'b0; tick(); rst = 1'b1;
    vectors++;
    if (st !== 28'h0000_00_0) begin
      $display("FAIL rst_mid: got %h want %h", st, 28'h0000_00_0); miscompares++;
    end
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    vectors++;
    if (st !== 28'h0000_00_0) begin
      $display("FAIL idle_ignore: got %h want %h", st, 28'h0000_00_0); miscompares++;
    end
  endtask

  task automatic test_ack_start();
    do_start();
    send_word(16'h00FF);
    vectors++;
    if (st !== 28'h00FF_10_4) begin
      $display("FAIL coll_full: got %h want %h", st, 28'h00FF_10_4); miscompares++;
    end
    word_ack = 1'b1; start = 1'b1; tick(); word_ack = 1'b0; start = 1'b0;
    vectors++;
    if (st !== 28'h0000_00_2) begin
      $display("FAIL coll_start_wins: got %h want %h", st, 28'h0000_00_2); miscompares++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_gapped();
    test_restart();
    test_overrun();
    test_reset_mid();
    test_ack_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
